sprite_blitter: RTL and testbench
=================================

SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have parameter SPRITE_W, default 20, meaning sprite width in pixels.
REQ-002 SHALL have parameter SPRITE_H, default 20, meaning sprite height in pixels.
REQ-003 SHALL have parameter CELL, default 20, meaning grid pitch in pixels.
REQ-004 SHALL have parameter NUM_SPRITES, default 4, meaning sprites stored back-to-back in ROM.
REQ-005 SHALL have parameter ROM_LAT, default 2, meaning ROM read latency in cycles (1..4).
REQ-006 SHALL have parameters SCREEN_W 160, SCREEN_H 120, COLOUR_W 9, meaning clip bounds and pixel width.
REQ-007 SHALL have ports: clk in 1 system clock; reset in 1 synchronous active-high reset.
REQ-008 SHALL have ports: start in 1 draw request; grid_x in 4 cell column; grid_y in 4 cell row; sprite_id in clog2(NUM_SPRITES) sprite select.
REQ-009 SHALL have ports: busy out 1 draw in progress; done out 1 single-cycle completion pulse.
REQ-010 SHALL have ports: rom_addr out clog2(NUM_SPRITES*SPRITE_W*SPRITE_H) registered ROM address; rom_data in COLOUR_W ROM data.
REQ-011 SHALL have ports: plot out 1 pixel write strobe; x out 8; y out 7; colour out COLOUR_W.

Function
REQ-012 SHALL use states IDLE, FETCH, DRAIN: IDLE->FETCH on start; FETCH->DRAIN after last address; DRAIN->IDLE after ROM_LAT cycles, pulsing done.
REQ-013 SHALL latch grid_x, grid_y and sprite_id when start is accepted in IDLE; start SHALL be ignored when busy.
REQ-014 SHALL assert busy from the cycle after start acceptance until the done cycle inclusive.
REQ-015 SHALL issue pixel k (row-major, col fastest) as rom_addr = sprite_id*W*H + row*W + col in cycle 1+k after the start edge.
REQ-016 SHALL assert plot for pixel k in cycle 1+k+ROM_LAT, with colour = rom_data and x/y delay-matched to the ROM.
REQ-017 SHALL compute x = grid_x*CELL + col and y = grid_y*CELL + row at full width, without truncation before clipping.
REQ-018 SHALL suppress plot for any pixel with full-width x >= SCREEN_W or y >= SCREEN_H, keeping pixel timing unchanged.
REQ-019 SHALL pulse done in the cycle after the last pixel slot (cycle 1+W*H+ROM_LAT), including when all pixels are clipped.
REQ-020 SHALL accept start again in the cycle after done.

Reset
REQ-021 SHALL clear plot, done and busy to 0, x, y, colour and rom_addr to 0, state to IDLE, and the delay pipeline valid bits on reset.
REQ-022 SHALL abort reset asserted mid-draw with no further plot and no done.

Configuration
REQ-023 SHALL, with SPRITE_BLITTER_TRANSPARENCY_EN defined, suppress plot for pixels whose colour equals parameter KEY_COLOUR (default 9'h1FF), with timing and done unchanged.
REQ-024 SHALL, without SPRITE_BLITTER_TRANSPARENCY_EN, plot every unclipped pixel regardless of colour.

Structure
REQ-025 SHALL place the state encoding and default geometry constants (CELL, SCREEN_W, SCREEN_H, COLOUR_W) in shared package draw_pkg.
REQ-026 SHALL use one sub-module, blit_delay_line, a ROM_LAT-deep shift register carrying {valid, x, y}.

Verification
REQ-027 SHALL cover: defaults, start at cell (3,2) with sprite 0 -> first plot x=60 y=40 at cycle 3, last plot x=79 y=59 at cycle 402, done at cycle 403, 400 plots.
REQ-028 SHALL cover: sprite_id=2 -> first rom_addr 800, last rom_addr 1199.
REQ-029 SHALL cover: cell (7,6) -> zero plots, done at cycle 403; cell (7,5) -> 400 plots, max x=159 y=119.
REQ-030 SHALL cover: start re-pulsed at cycle 50 of a draw -> ignored, exactly one done.
REQ-031 SHALL cover: reset at cycle 100 -> plot/busy low next cycle, no done, and a new start completes normally.
REQ-032 SHALL cover: TRANSPARENCY_EN with ROM pixels 0..9 = 9'h1FF -> 390 plots; ROM_LAT=4 -> first plot at cycle 5, done at cycle 405.

Source files
------------

// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared blitter state encoding, geometry defaults and width helper
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } blit_state_e;

  localparam int DEF_CELL     = 20;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int DEF_COLOUR_W = 9;

  // Width of a counter/index covering v values, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/blit_delay_line.sv
// rtl/blit_delay_line.sv - DEPTH-deep shift register carrying {valid, x, y} alongside the ROM
module blit_delay_line #(
  parameter int DEPTH = 2,
  parameter int XW    = 8,
  parameter int YW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_i,
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  output logic          valid_o,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o
);

  logic [DEPTH-1:0] valid_q;
  logic [XW-1:0]    x_q [DEPTH];
  logic [YW-1:0]    y_q [DEPTH];

  // Shift the pixel coordinates so they emerge in the same cycle as the ROM data.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      x_q[0]     <= x_i;
      y_q[0]     <= y_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        x_q[i]     <= x_q[i-1];
        y_q[i]     <= y_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign x_o     = x_q[DEPTH-1];
  assign y_o     = y_q[DEPTH-1];

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - grid-aligned sprite blitter; SPRITE_BLITTER_TRANSPARENCY_EN enables colour-key transparency
module sprite_blitter
  import draw_pkg::*;
#(
  parameter int SPRITE_W    = 20,
  parameter int SPRITE_H    = 20,
  parameter int CELL        = DEF_CELL,
  parameter int NUM_SPRITES = 4,
  parameter int ROM_LAT     = 2,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int COLOUR_W    = DEF_COLOUR_W,
`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = {COLOUR_W{1'b1}},
`endif
  localparam int SID_W = clog2_min1(NUM_SPRITES),
  localparam int AW    = clog2_min1(NUM_SPRITES * SPRITE_W * SPRITE_H)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [3:0]          grid_x,
  input  logic [3:0]          grid_y,
  input  logic [SID_W-1:0]    sprite_id,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic                plot,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour
);

  localparam int CW = clog2_min1(SPRITE_W);
  localparam int RW = clog2_min1(SPRITE_H);
  // Wide enough for 15*CELL + SPRITE_W so off-screen pixels never alias on-screen.
  localparam int FW = 16;

  blit_state_e   state_q, state_d;
  logic [3:0]    gx_q, gx_d, gy_q, gy_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    drain_q, drain_d;

  logic          last_pix;
  logic [FW-1:0] x_full, y_full;
  logic          in_bounds;
  logic          dl_valid;
  logic [7:0]    dl_x;
  logic [6:0]    dl_y;

  assign last_pix = (col_q == CW'(SPRITE_W - 1)) && (row_q == RW'(SPRITE_H - 1));

  // State, latched draw parameters and the address walk.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gx_q    <= '0;
      gy_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
    end
  end

  // Next-state: accept in IDLE, walk row-major in FETCH, wait out the ROM in DRAIN.
  always_comb begin
    state_d = state_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          gx_d    = grid_x;
          gy_d    = grid_y;
          col_d   = '0;
          row_d   = '0;
          addr_d  = AW'(sprite_id) * AW'(SPRITE_W * SPRITE_H);
        end
      end
      FETCH: begin
        if (last_pix) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          addr_d = addr_q + AW'(1);
          if (col_q == CW'(SPRITE_W - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_q == 3'(ROM_LAT)) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clip on full-width coordinates of the pixel whose address is on the bus now.
  always_comb begin
    x_full    = FW'(gx_q) * FW'(CELL) + FW'(col_q);
    y_full    = FW'(gy_q) * FW'(CELL) + FW'(row_q);
    in_bounds = (x_full < FW'(SCREEN_W)) && (y_full < FW'(SCREEN_H));
  end

  blit_delay_line #(
    .DEPTH (ROM_LAT),
    .XW    (8),
    .YW    (7)
  ) u_delay (
    .clk     (clk),
    .reset   (reset),
    .valid_i ((state_q == FETCH) && in_bounds),
    .x_i     (x_full[7:0]),
    .y_i     (y_full[6:0]),
    .valid_o (dl_valid),
    .x_o     (dl_x),
    .y_o     (dl_y)
  );

  assign busy     = (state_q != IDLE);
  assign rom_addr = addr_q;
  assign x        = dl_x;
  assign y        = dl_y;
  assign colour   = dl_valid ? rom_data : '0;

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  assign plot = dl_valid && (rom_data != KEY_COLOUR);
`else
  assign plot = dl_valid;
`endif

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - self-checking bench for sprite_blitter (ROM_LAT 2 and 4 instances)
module tb_sprite_blitter;

`ifdef SPRITE_BLITTER_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif
  localparam int NPIX = 400;

  logic clk = 1'b0;
  logic reset, start_a, start_b;
  logic [3:0] gx_s, gy_s;
  logic [1:0] sid_s;
  logic busy_a, done_a, plot_a, busy_b, done_b, plot_b;
  logic [10:0] rom_addr_a, rom_addr_b;
  logic [8:0] rom_data_a, rom_data_b, colour_a, colour_b;
  logic [7:0] x_a, x_b;
  logic [6:0] y_a, y_b;
  logic sel;
  logic [8:0] rom [0:2047];
  logic [10:0] pa [2];
  logic [10:0] pb [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sprite_blitter #(.ROM_LAT(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .grid_x(gx_s), .grid_y(gy_s),
    .sprite_id(sid_s), .busy(busy_a), .done(done_a), .rom_addr(rom_addr_a),
    .rom_data(rom_data_a), .plot(plot_a), .x(x_a), .y(y_a), .colour(colour_a));

  sprite_blitter #(.ROM_LAT(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .grid_x(gx_s), .grid_y(gy_s),
    .sprite_id(sid_s), .busy(busy_b), .done(done_b), .rom_addr(rom_addr_b),
    .rom_data(rom_data_b), .plot(plot_b), .x(x_b), .y(y_b), .colour(colour_b));

  // Behavioural ROMs: data appears ROM_LAT cycles after the address.
  always @(posedge clk) begin
    pa[0] <= rom_addr_a;
    pa[1] <= pa[0];
    pb[0] <= rom_addr_b;
    for (int i = 1; i < 4; i++) pb[i] <= pb[i-1];
  end
  assign rom_data_a = rom[pa[1]];
  assign rom_data_b = rom[pb[3]];

  wire       m_busy = sel ? busy_b : busy_a;
  wire       m_done = sel ? done_b : done_a;
  wire       m_plot = sel ? plot_b : plot_a;
  wire [7:0] m_x    = sel ? x_b : x_a;
  wire [6:0] m_y    = sel ? y_b : y_a;
  wire [8:0] m_col  = sel ? colour_b : colour_a;
  wire [10:0] m_addr = sel ? rom_addr_b : rom_addr_a;

  typedef struct {
    int gx, gy, sid, plots, fc, fx, fy, lc, lx, ly, a0, a1, dc;
  } vec_t;

  typedef struct {
    int plots, fc, fx, fy, lc, lx, ly, a0, a1, dc, dcnt, merr, mfirst, rb, ra;
  } st_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Drive one draw and compare every cycle against expectations derived from
  // the pixel index k = cycle - 1 - latency.
  task automatic run_draw(input bit s_b, input int gx, input int gy, input int sid,
                          input int repulse_at, input int reset_at, input bit chain,
                          output st_t s);
    int L, base, dexp, k, xf, yf, nerr;
    bit active, pix, ep, eb, ed, chk_on;
    logic [8:0] rv;
    L = s_b ? 4 : 2;
    base = sid * NPIX;
    dexp = 1 + NPIX + L;
    s = '{default: 0};
    s.fc = -1; s.lc = -1; s.dc = -1; s.mfirst = -1;
    @(negedge clk);
    sel = s_b;
    gx_s = 4'(gx); gy_s = 4'(gy); sid_s = 2'(sid);
    start_a = !s_b; start_b = s_b;
    for (int n = 1; n <= L + 410; n++) begin
      @(negedge clk);
      if (chain && n == dexp + 2) begin
        s.rb = int'(m_busy);
        s.ra = int'(m_addr);
        start_a = 1'b0; start_b = 1'b0;
        break;
      end
      chk_on = !chain || (n <= dexp + 1);
      active = !(reset_at > 0 && n > reset_at);
      k = n - 1 - L;
      pix = active && (k >= 0) && (k < NPIX);
      xf = gx * 20 + ((k >= 0) ? k % 20 : 0);
      yf = gy * 20 + ((k >= 0) ? k / 20 : 0);
      rv = pix ? rom[base + k] : 9'd0;
      ep = pix && (xf < 160) && (yf < 120) && !(TRANSP && rv == 9'h1FF);
      eb = active && (n <= dexp);
      ed = active && (n == dexp);
      nerr = 0;
      if (chk_on) begin
        if (m_busy !== eb) nerr++;
        if (m_done !== ed) nerr++;
        if (m_plot !== ep) nerr++;
        if (ep && (m_x !== 8'(xf) || m_y !== 7'(yf) || m_col !== rv)) nerr++;
        if (active && n <= NPIX && int'(m_addr) != base + n - 1) nerr++;
        if (!active && m_addr !== 11'd0) nerr++;
      end
      if (nerr > 0) begin
        s.merr += nerr;
        if (s.mfirst < 0) s.mfirst = n;
      end
      if (m_plot) begin
        s.plots++;
        if (s.fc < 0) begin s.fc = n; s.fx = int'(m_x); s.fy = int'(m_y); end
        s.lc = n; s.lx = int'(m_x); s.ly = int'(m_y);
      end
      if (m_done) begin
        s.dcnt++;
        if (s.dc < 0) s.dc = n;
      end
      if (n == 1) s.a0 = int'(m_addr);
      if (n == NPIX) s.a1 = int'(m_addr);
      // Inputs change after acceptance so latching is exercised.
      if (n == 1) begin
        start_a = 1'b0; start_b = 1'b0;
        gx_s = ~gx_s; gy_s = ~gy_s; sid_s = sid_s + 2'd1;
      end
      if (chain && n == dexp + 1) begin
        gx_s = 4'(gx); gy_s = 4'(gy); sid_s = 2'(sid);
        start_a = !s_b; start_b = s_b;
      end
      if (n == repulse_at) begin
        start_a = !s_b; start_b = s_b;
        gx_s = 4'd0; gy_s = 4'd0;
      end
      if (n == repulse_at + 1) begin start_a = 1'b0; start_b = 1'b0; end
      if (n == reset_at) reset = 1'b1;
      if (n == reset_at + 1) reset = 1'b0;
    end
  endtask

  vec_t vecs[9];
  st_t st;
  logic [8:0] saved [10];
  bit seen;
  int rgx, rgy, rsid;
  bit rsel;

  initial begin
    vecs[0] = '{3, 2, 0, 400, 3, 60, 40, 402, 79, 59, 0, 399, 403};
    vecs[1] = '{1, 1, 2, 400, 3, 20, 20, 402, 39, 39, 800, 1199, 403};
    vecs[2] = '{7, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 399, 403};
    vecs[3] = '{7, 5, 1, 400, 3, 140, 100, 402, 159, 119, 400, 799, 403};
    vecs[4] = '{7, 0, 3, 400, 3, 140, 0, 402, 159, 19, 1200, 1599, 403};
    vecs[5] = '{8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 399, 403};
    vecs[6] = '{0, 5, 3, 400, 3, 0, 100, 402, 19, 119, 1200, 1599, 403};
    vecs[7] = '{15, 15, 1, 0, 0, 0, 0, 0, 0, 0, 400, 799, 403};
    vecs[8] = '{13, 0, 2, 0, 0, 0, 0, 0, 0, 0, 800, 1199, 403};

    for (int i = 0; i < 2048; i++) rom[i] = 9'($urandom_range(0, 510));
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    gx_s = '0; gy_s = '0; sid_s = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_done", int'(done_a), 0);
    chk("reset_plot", int'(plot_a), 0);
    chk("reset_xy", int'({x_a, y_a}), 0);
    chk("reset_colour", int'(colour_a), 0);
    chk("reset_rom_addr", int'(rom_addr_a), 0);
    chk("reset_b_busy_plot", int'({busy_b, plot_b, done_b}), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_draw(1'b0, vecs[i].gx, vecs[i].gy, vecs[i].sid, 0, 0, 1'b0, st);
      chk($sformatf("v%0d_plots", i), st.plots, vecs[i].plots);
      if (vecs[i].plots > 0) begin
        chk($sformatf("v%0d_first_cycle", i), st.fc, vecs[i].fc);
        chk($sformatf("v%0d_first_x", i), st.fx, vecs[i].fx);
        chk($sformatf("v%0d_first_y", i), st.fy, vecs[i].fy);
        chk($sformatf("v%0d_last_cycle", i), st.lc, vecs[i].lc);
        chk($sformatf("v%0d_last_x", i), st.lx, vecs[i].lx);
        chk($sformatf("v%0d_last_y", i), st.ly, vecs[i].ly);
      end
      chk($sformatf("v%0d_first_addr", i), st.a0, vecs[i].a0);
      chk($sformatf("v%0d_last_addr", i), st.a1, vecs[i].a1);
      chk($sformatf("v%0d_done_cycle", i), st.dc, vecs[i].dc);
      chk($sformatf("v%0d_done_count", i), st.dcnt, 1);
      chk($sformatf("v%0d_model_errs_from_cycle_%0d", i, st.mfirst), st.merr, 0);
    end

    // Start re-pulsed mid-draw must be ignored.
    run_draw(1'b0, 3, 2, 0, 50, 0, 1'b0, st);
    chk("repulse_done_count", st.dcnt, 1);
    chk("repulse_done_cycle", st.dc, 403);
    chk("repulse_model_errs", st.merr, 0);

    // Reset mid-draw aborts with no done; plots only up to cycle 100.
    run_draw(1'b0, 3, 2, 0, 0, 100, 1'b0, st);
    chk("abort_done_count", st.dcnt, 0);
    chk("abort_plots", st.plots, 98);
    chk("abort_model_errs", st.merr, 0);
    run_draw(1'b0, 3, 2, 0, 0, 0, 1'b0, st);
    chk("after_abort_plots", st.plots, 400);
    chk("after_abort_done_cycle", st.dc, 403);

    // Start in the cycle after done is accepted.
    run_draw(1'b0, 1, 1, 2, 0, 0, 1'b1, st);
    chk("chain_model_errs", st.merr, 0);
    chk("chain_busy", st.rb, 1);
    chk("chain_addr", st.ra, 800);
    seen = 1'b0;
    for (int t = 0; t < 500 && !seen; t++) begin
      @(negedge clk);
      if (done_a) seen = 1'b1;
    end
    chk("chain_second_done", int'(seen), 1);

    // Longer ROM latency shifts plots and done.
    run_draw(1'b1, 3, 2, 0, 0, 0, 1'b0, st);
    chk("lat4_first_cycle", st.fc, 5);
    chk("lat4_first_x", st.fx, 60);
    chk("lat4_done_cycle", st.dc, 405);
    chk("lat4_plots", st.plots, 400);
    chk("lat4_model_errs", st.merr, 0);

    // Key-coloured pixels: dropped only when transparency is built in.
    for (int i = 0; i < 10; i++) begin saved[i] = rom[i]; rom[i] = 9'h1FF; end
    run_draw(1'b0, 3, 2, 0, 0, 0, 1'b0, st);
    chk("key_plots", st.plots, TRANSP ? 390 : 400);
    chk("key_done_cycle", st.dc, 403);
    chk("key_model_errs", st.merr, 0);
    for (int i = 0; i < 10; i++) rom[i] = saved[i];

    // Random draws against the cycle model.
    for (int i = 0; i < 6; i++) begin
      rgx = $urandom_range(0, 15);
      rgy = $urandom_range(0, 15);
      rsid = $urandom_range(0, 3);
      rsel = 1'($urandom_range(0, 1));
      run_draw(rsel, rgx, rgy, rsid, 0, 0, 1'b0, st);
      chk($sformatf("rand%0d_g%0d_%0d_s%0d_model_errs", i, rgx, rgy, rsid), st.merr, 0);
      chk($sformatf("rand%0d_done_count", i), st.dcnt, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
